// File: rtl/three_bit_reg.sv
// three_bit_reg: loadable register with a sticky Loaded flag and async active-low reset.
// Define THREE_BIT_REG_PARITY_EN to add a registered even-parity output of Q.
`timescale 1ns/100ps
module three_bit_reg #(
  parameter int WIDTH = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic [WIDTH-1:0] D,
  input  logic             Load,
  output logic [WIDTH-1:0] Q,
  input  logic             RST_N,
  output logic             Loaded
`ifdef THREE_BIT_REG_PARITY_EN
  ,
  output logic             Parity
`endif
);
  // armed blocks a load on the edge that releases reset, so the first load lands one edge later
  logic armed;
  logic ld;
  assign ld = armed & Load;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q      <= RESET_VAL;
      Loaded <= 1'b0;
      armed  <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (ld) begin
        Q      <= D;
        Loaded <= 1'b1;
      end
    end
  end
`ifdef THREE_BIT_REG_PARITY_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) Parity <= ^RESET_VAL;
    else if (ld) Parity <= ^D;
  end
`endif
endmodule

// File: tb/tb_three_bit_reg.sv
// tb_three_bit_reg: random and directed checks of three_bit_reg against a behavioural model.
`timescale 1ns/100ps
module tb_three_bit_reg;
  logic       CLK;
  logic [2:0] D;
  logic       Load;
  logic [2:0] Q;
  logic       RST_N;
  logic       Loaded;
`ifdef THREE_BIT_REG_PARITY_EN
  logic       Parity;
`endif
  int total = 0;
  int bad = 0;
  logic [2:0] m_q = 3'b000;
  logic       m_loaded = 1'b0;
  int         since_rel = 0;

  three_bit_reg dut (
    .CLK(CLK),
    .D(D),
    .Load(Load),
    .Q(Q),
    .RST_N(RST_N),
    .Loaded(Loaded)
`ifdef THREE_BIT_REG_PARITY_EN
    ,
    .Parity(Parity)
`endif
  );

  always #1 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, "_q"}, 32'(Q), 32'(m_q));
    check({tag, "_loaded"}, 32'(Loaded), 32'(m_loaded));
`ifdef THREE_BIT_REG_PARITY_EN
    check({tag, "_parity"}, 32'(Parity), 32'(^m_q));
`endif
  endtask

  // Drive at a falling edge, advance the model at the rising edge, check at the next falling edge.
  // A load needs at least one prior edge with reset released.
  task automatic step(input string tag, input logic [2:0] d, input logic ld);
    D = d;
    Load = ld;
    @(posedge CLK);
    if (RST_N) begin
      if (since_rel > 0 && ld) begin
        m_q = d;
        m_loaded = 1'b1;
      end
      since_rel++;
    end
    #0.3 D = ~d;
    @(negedge CLK);
    check_out(tag);
  endtask

  task automatic async_rst();
    D = 3'($urandom);
    Load = 1'b1;
    #0.5 RST_N = 1'b0;
    m_q = 3'b000;
    m_loaded = 1'b0;
    #0.1 check_out("async_rst");
    @(negedge CLK);
    check_out("rst_hold");
  endtask

  task automatic rel();
    RST_N = 1'b1;
    since_rel = 0;
  endtask

  initial begin
    CLK = 1'b0;
    RST_N = 1'b1;
    D = 3'b010;
    Load = 1'b0;
    #0.2 RST_N = 1'b0;
    #0.2 check_out("por");
    #0.1 rel();
    step("idle", 3'b010, 1'b0);
    step("load_held", 3'b010, 1'b1);
    check("load_held_val", 32'(Q), 32'd2);
    repeat (3) step("hold", 3'b111, 1'b0);
    check("hold_val", 32'(Q), 32'd2);
    step("b2b_a", 3'b001, 1'b1);
    step("b2b_b", 3'b110, 1'b1);
    step("b2b_c", 3'b011, 1'b1);
    step("par_odd", 3'b111, 1'b1);
    step("par_even", 3'b011, 1'b1);
    step("pre_rst", 3'b101, 1'b1);
    async_rst();
    step("ld_in_rst", 3'b111, 1'b1);
    step("ld_in_rst2", 3'b111, 1'b1);
    rel();
    step("rel_edge", 3'b111, 1'b1);
    check("rel_edge_val", 32'(Q), 32'd0);
    step("rel_next", 3'b111, 1'b1);
    check("rel_next_val", 32'(Q), 32'd7);
    async_rst();
    rel();
    step("arm", 3'b000, 1'b0);
    step("same_val", 3'b000, 1'b1);
    check("same_val_flag", 32'(Loaded), 32'd1);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(15) == 0) begin
        async_rst();
        repeat ($urandom_range(2)) step("rnd_in_rst", 3'($urandom), 1'($urandom));
        rel();
      end else begin
        step("rnd", 3'($urandom), 1'($urandom_range(3) != 0));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
